preg_free_list: RTL and testbench

PREG_FREE_LIST -- requirements
Module: preg_free_list

---
 rtl/types_pkg.sv | 45 ++++
 rtl/freelist_ckpt_table.sv | 72 +++++++
 rtl/preg_free_list.sv | 132 +++++++++++++
 tb/tb_preg_free_list.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types and defaults for the physical-register free list.
// Holds the tag/checkpoint-id types, the free-list pointer struct and
// pointer arithmetic helpers used by preg_free_list and its checkpoint table.
package types_pkg;

    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int NUM_CKPT  = 4;

    typedef logic [6:0] preg_t;
    typedef logic [1:0] ckpt_id_t;

    // Circular-buffer pointer: slot index plus a wrap bit that toggles on
    // every pass, so equal indices can be told apart as empty or full.
    typedef struct packed {
        logic       wrap;
        logic [6:0] idx;
    } fl_ptr_t;

    // Advance a pointer by one slot, wrapping last_idx -> 0 with a wrap toggle.
    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p, input logic [6:0] last_idx);
        fl_ptr_t r;
        if (p.idx == last_idx) begin
            r.idx  = 7'd0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + 7'd1;
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    // Number of entries between head and tail, taking the wrap bits into account.
    function automatic logic [6:0] ptr_dist(input fl_ptr_t tail, input fl_ptr_t head,
                                            input logic [6:0] depth);
        logic [6:0] d;
        if (tail.wrap == head.wrap) begin
            d = tail.idx - head.idx;
        end else begin
            d = depth - head.idx + tail.idx;
        end
        return d;
    endfunction

endpackage

// File: rtl/freelist_ckpt_table.sv
// Branch checkpoint table for the free list: one valid bit and one saved
// head pointer per slot. Single write port (save), single read port
// (restore). A save into a valid slot, or while every slot is valid, is
// dropped here. The full flag is registered so it never depends
// combinationally on the current cycle's inputs.
module freelist_ckpt_table #(
    parameter int NUM_CKPT = types_pkg::NUM_CKPT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  types_pkg::ckpt_id_t wr_id,
    input  types_pkg::fl_ptr_t  wr_ptr,
    input  logic                clr_en,
    input  types_pkg::ckpt_id_t clr_id,
    input  logic                clr_all,
    input  types_pkg::ckpt_id_t rd_id,
    output types_pkg::fl_ptr_t  rd_ptr,
    output logic                rd_valid,
    output logic                full
);

    logic [NUM_CKPT-1:0] valid_r;
    logic [NUM_CKPT-1:0] valid_nxt_s;
    logic                full_r;
    logic                wr_ok_s;
    types_pkg::fl_ptr_t  saved_r [NUM_CKPT];

    assign wr_ok_s  = wr_en && !valid_r[wr_id] && !full_r;
    assign rd_ptr   = saved_r[rd_id];
    assign rd_valid = valid_r[rd_id];
    assign full     = full_r;

    // Next-state of the valid bits: flush beats save, save beats free.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (clr_all) begin
                valid_nxt_s[i] = 1'b0;
            end else if (wr_ok_s && (int'(wr_id) == i)) begin
                valid_nxt_s[i] = 1'b1;
            end else if (clr_en && (int'(clr_id) == i)) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i];
            end
        end
    end

    // Valid bits and the registered all-valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
            full_r  <= 1'b0;
        end else begin
            valid_r <= valid_nxt_s;
            full_r  <= &valid_nxt_s;
        end
    end

    // Saved head pointers, written only by an accepted save.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                saved_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            saved_r[wr_id] <= wr_ptr;
        end
    end

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: circular FIFO of free tags with head
// (allocate) and tail (release) pointers, branch checkpoints of the head
// pointer and a one-cycle RECOVER state after a mispredict restore.
// Optional macro FREELIST_STATS_EN adds a saturating allocation-stall
// counter on stall_cnt; without it stall_cnt is tied to zero.
module preg_free_list #(
    parameter int NUM_PREGS = types_pkg::NUM_PREGS,
    parameter int NUM_AREGS = types_pkg::NUM_AREGS,
    parameter int NUM_CKPT  = types_pkg::NUM_CKPT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_req,
    output logic                alloc_gnt,
    output types_pkg::preg_t    alloc_preg,
    input  logic                write_en,
    input  types_pkg::preg_t    rob_data_in,
    input  logic                ckpt_save,
    input  types_pkg::ckpt_id_t ckpt_save_id,
    input  logic                ckpt_free,
    input  types_pkg::ckpt_id_t ckpt_free_id,
    input  logic                mispredict,
    input  types_pkg::ckpt_id_t mispredict_id,
    output logic                ckpt_full,
    output logic [6:0]          free_count,
    output logic                overflow_err,
    output logic [31:0]         stall_cnt
);

    localparam int         DEPTH    = NUM_PREGS - NUM_AREGS;
    localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
    localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    types_pkg::preg_t   buf_r [DEPTH];
    types_pkg::fl_ptr_t head_r, tail_r;
    types_pkg::fl_ptr_t head_alloc_s, head_nxt_s, tail_nxt_s;
    types_pkg::fl_ptr_t ckpt_rd_ptr_s;
    logic [0:0]         state_r, state_nxt_s;
    logic [6:0]         count_s;
    logic               ckpt_rd_valid_s;
    logic               mp_ok_s;
    logic               rel_live_s;
    logic               rel_ok_s;
    logic               rel_drop_s;
    logic               overflow_r;

    assign count_s      = types_pkg::ptr_dist(tail_r, head_r, DEPTH_C);
    assign free_count   = count_s;
    assign alloc_preg   = buf_r[head_r.idx];
    assign alloc_gnt    = alloc_req && (count_s != 7'd0) && (state_r == ST_RUN) && !mispredict;
    assign mp_ok_s      = mispredict && ckpt_rd_valid_s;
    assign rel_live_s   = write_en && (rob_data_in != 7'd0);
    assign rel_ok_s     = rel_live_s && (count_s != DEPTH_C);
    assign rel_drop_s   = rel_live_s && (count_s == DEPTH_C);
    assign overflow_err = overflow_r;

    // Pointer and FSM next-state; a restore overrides the allocation advance.
    always_comb begin
        head_alloc_s = alloc_gnt ? types_pkg::ptr_inc(head_r, LAST_IDX) : head_r;
        head_nxt_s   = mp_ok_s ? ckpt_rd_ptr_s : head_alloc_s;
        tail_nxt_s   = rel_ok_s ? types_pkg::ptr_inc(tail_r, LAST_IDX) : tail_r;
        case (state_r)
            ST_RUN:     state_nxt_s = mp_ok_s ? ST_RECOVER : ST_RUN;
            ST_RECOVER: state_nxt_s = ST_RUN;
            default:    state_nxt_s = ST_RUN;
        endcase
    end

    // Pointers, FSM state and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r     <= '{wrap: 1'b0, idx: 7'd0};
            tail_r     <= '{wrap: 1'b1, idx: 7'd0};
            state_r    <= ST_RUN;
            overflow_r <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            state_r    <= state_nxt_s;
            overflow_r <= overflow_r | rel_drop_s;
        end
    end

    // Tag storage: preloaded with the non-architectural tags, refilled at tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= types_pkg::preg_t'(NUM_AREGS + i);
            end
        end else if (rel_ok_s) begin
            buf_r[tail_r.idx] <= rob_data_in;
        end
    end

    freelist_ckpt_table #(
        .NUM_CKPT (NUM_CKPT)
    ) u_ckpt (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ckpt_save && !mp_ok_s),
        .wr_id    (ckpt_save_id),
        .wr_ptr   (head_alloc_s),
        .clr_en   (ckpt_free && !mp_ok_s),
        .clr_id   (ckpt_free_id),
        .clr_all  (mp_ok_s),
        .rd_id    (mispredict_id),
        .rd_ptr   (ckpt_rd_ptr_s),
        .rd_valid (ckpt_rd_valid_s),
        .full     (ckpt_full)
    );

`ifdef FREELIST_STATS_EN
    logic [31:0] stall_r;

    // Saturating count of cycles where rename asked but got no tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_r <= 32'd0;
        end else if (alloc_req && !alloc_gnt && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end
    end

    assign stall_cnt = stall_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list. The reference model treats the
// free list as the sequence of every tag ever made free plus two counters
// (how many were taken, how many were given); checkpoints remember the
// "taken" count. Directed scenarios first, then randomized traffic.
// Set FREELIST_STATS_EN to exercise the stall counter.
module tb_preg_free_list;

    localparam int DEPTH = 96;
`ifdef FREELIST_STATS_EN
    localparam int EXP_STALL10 = 10;
`else
    localparam int EXP_STALL10 = 0;
`endif

    logic        clk;
    logic        reset;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [6:0]  alloc_preg;
    logic        write_en;
    logic [6:0]  rob_data_in;
    logic        ckpt_save;
    logic [1:0]  ckpt_save_id;
    logic        ckpt_free;
    logic [1:0]  ckpt_free_id;
    logic        mispredict;
    logic [1:0]  mispredict_id;
    logic        ckpt_full;
    logic [6:0]  free_count;
    logic        overflow_err;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          seq[$];
    int          popped;
    int          pushed;
    bit [3:0]    ck_valid;
    int          ck_pos[4];
    bit          rec;
    bit          ovf;
    int unsigned stall;

    preg_free_list dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_preg    (alloc_preg),
        .write_en      (write_en),
        .rob_data_in   (rob_data_in),
        .ckpt_save     (ckpt_save),
        .ckpt_save_id  (ckpt_save_id),
        .ckpt_free     (ckpt_free),
        .ckpt_free_id  (ckpt_free_id),
        .mispredict    (mispredict),
        .mispredict_id (mispredict_id),
        .ckpt_full     (ckpt_full),
        .free_count    (free_count),
        .overflow_err  (overflow_err),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        seq.delete();
        for (int i = 0; i < DEPTH; i++) seq.push_back(32 + i);
        popped   = 0;
        pushed   = DEPTH;
        ck_valid = 4'b0000;
        rec      = 1'b0;
        ovf      = 1'b0;
        stall    = 0;
    endtask

    task automatic model_check();
        int cnt;
        bit exp_gnt;
        cnt     = pushed - popped;
        exp_gnt = alloc_req && (cnt != 0) && !rec && !mispredict;
        chk("alloc_gnt", 32'(alloc_gnt), 32'(exp_gnt));
        chk("free_count", 32'(free_count), 32'(cnt));
        if (cnt != 0) chk("alloc_preg", 32'(alloc_preg), 32'(seq[popped]));
        chk("ckpt_full", 32'(ckpt_full), 32'(&ck_valid));
        chk("overflow_err", 32'(overflow_err), 32'(ovf));
        chk("stall_cnt", stall_cnt, stall);
    endtask

    // Advance the model by one clock using the applied inputs, then clock the DUT.
    task automatic tick();
        int cnt;
        bit gnt_m, mp_ok, full_pre, save_ok;
        cnt      = pushed - popped;
        full_pre = &ck_valid;
        mp_ok    = mispredict && ck_valid[mispredict_id];
        gnt_m    = alloc_req && (cnt != 0) && !rec && !mispredict;
        save_ok  = ckpt_save && !mp_ok && !ck_valid[ckpt_save_id] && !full_pre;
`ifdef FREELIST_STATS_EN
        if (alloc_req && !gnt_m && stall != 32'hFFFF_FFFF) stall++;
`endif
        if (gnt_m) popped++;
        if (write_en && rob_data_in != 7'd0) begin
            if (cnt < DEPTH) begin
                seq.push_back(int'(rob_data_in));
                pushed++;
            end else begin
                ovf = 1'b1;
            end
        end
        if (mp_ok) begin
            popped   = ck_pos[mispredict_id];
            ck_valid = 4'b0000;
            rec      = 1'b1;
        end else begin
            rec = 1'b0;
            if (ckpt_free) ck_valid[ckpt_free_id] = 1'b0;
            if (save_ok) begin
                ck_valid[ckpt_save_id] = 1'b1;
                ck_pos[ckpt_save_id]   = popped;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit req, input bit wen, input int wdata,
                         input bit sv, input int sid, input bit fr, input int fid,
                         input bit mp, input int mid);
        alloc_req     = req;
        write_en      = wen;
        rob_data_in   = 7'(wdata);
        ckpt_save     = sv;
        ckpt_save_id  = 2'(sid);
        ckpt_free     = fr;
        ckpt_free_id  = 2'(fid);
        mispredict    = mp;
        mispredict_id = 2'(mid);
        #1;
        model_check();
    endtask

    // Assert reset between edges, check the asynchronous clear, release at a falling edge.
    task automatic do_reset();
        alloc_req = 1'b0; write_en = 1'b0; rob_data_in = 7'd0;
        ckpt_save = 1'b0; ckpt_save_id = 2'd0; ckpt_free = 1'b0; ckpt_free_id = 2'd0;
        mispredict = 1'b0; mispredict_id = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        model_check();
        chk("rst_alloc_preg", 32'(alloc_preg), 32'd32);
        chk("rst_free_count", 32'(free_count), 32'd96);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit r_req, r_wen, r_sv, r_fr, r_mp;
        int r_data, base;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // 96 back-to-back allocations drain the list in tag order
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("drain_gnt", 32'(alloc_gnt), 32'd1);
            chk("drain_preg", 32'(alloc_preg), 32'(32 + i));
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("empty_count", 32'(free_count), 32'd0);
        chk("empty_gnt", 32'(alloc_gnt), 32'd0);
        tick();

        // Release into empty list with a same-cycle request: grant waits a cycle
        drive(1, 1, 40, 0, 0, 0, 0, 0, 0);
        chk("empty_rel_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("refill_gnt", 32'(alloc_gnt), 32'd1);
        chk("refill_preg", 32'(alloc_preg), 32'd40);
        tick();

        // Checkpoint, allocate past it, mispredict back to it
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("recover_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("restore_gnt", 32'(alloc_gnt), 32'd1);
        chk("restore_preg", 32'(alloc_preg), 32'd35);
        chk("restore_count", 32'(free_count), 32'd93);
        tick();

        // Fill all checkpoint slots, a fifth save is dropped, freeing one clears full
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 1, i, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ckpt_full_set", 32'(ckpt_full), 32'd1);
        tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 2, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ckpt_full_clr", 32'(ckpt_full), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Release into a full list is dropped and sets the sticky error
        do_reset();
        drive(0, 1, 5, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_count", 32'(free_count), 32'd96);
        chk("ovf_set", 32'(overflow_err), 32'd1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("p0_count", 32'(free_count), 32'd96);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        tick();

        // Stall counting on an empty list
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
        for (int i = 0; i < 10; i++) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall10", stall_cnt, 32'(EXP_STALL10));
        tick();

        // Randomized traffic with mid-run resets
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 1000 == 999) do_reset();
            r_req  = ($urandom_range(0, 9) < 6);
            r_wen  = ($urandom_range(0, 9) < 5);
            r_data = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            r_sv   = ($urandom_range(0, 9) == 0);
            r_fr   = ($urandom_range(0, 11) == 0);
            r_mp   = ($urandom_range(0, 19) == 0);
            // Keep releases from overrunning tags still owed to a live checkpoint
            base = popped;
            for (int k = 0; k < 4; k++) if (ck_valid[k] && ck_pos[k] < base) base = ck_pos[k];
            if (ck_valid != 4'b0000 && (pushed - base) >= DEPTH) r_wen = 1'b0;
            drive(r_req, r_wen, r_data, r_sv, int'($urandom_range(0, 3)), r_fr,
                  int'($urandom_range(0, 3)), r_mp, int'($urandom_range(0, 3)));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
